// File: rtl/hdp_sram_ctrl_pkg.sv
// Shared constants and types for the dual-port SRAM port controller.
package hdp_sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 11;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;
  localparam int unsigned SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Port-0 request payload as seen by a master at the default macro geometry.
  typedef struct packed {
    logic                       we;
    logic [SRAM_NUM_WMASKS-1:0] wmask;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/hdp_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the master not granted last.
module hdp_rr_arb2
  import hdp_sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0 favours req[0], 1 favours req[1]
  logic ptr_q, ptr_d;

  // Grant is purely combinational from the requests and the pointer.
  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves to the other master after a grant, holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hdp_sram_port_ctrl.sv
// Port controller for a 1RW+1R SRAM macro: zero-fill after reset, round-robin sharing
// of port 0 between two masters, and a read-only requester on port 1.
module hdp_sram_port_ctrl
  import hdp_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [NUM_WMASKS-1:0] m0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [NUM_WMASKS-1:0] m1_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  input  logic                  r_req_valid,
  output logic                  r_req_ready,
  input  logic [ADDR_WIDTH-1:0] r_req_addr,
  output logic                  r_rsp_valid,
  output logic [DATA_WIDTH-1:0] r_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam ctrl_state_e StateAfterReset = (INIT_ZERO != 0) ? INIT : RUN;

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q;

  logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;

  logic [1:0]            gnt, pend_q;
  logic                  pend_we_q, r_pend_q;
  logic                  m0_rsp_valid_q, m1_rsp_valid_q, r_rsp_valid_q;
  logic [DATA_WIDTH-1:0] m0_rsp_rdata_q, m1_rsp_rdata_q, r_rsp_rdata_q;

  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  p0_accept, collision, r_accept;

  // Requests are only considered once the array is ready (one cycle after entering RUN).
  hdp_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1_req_valid, m0_req_valid}),
    .advance (init_done_q),
    .gnt     (gnt)
  );

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];
  assign p0_accept    = |gnt;

  assign sel_we    = gnt[1] ? m1_req_we    : m0_req_we;
  assign sel_wmask = gnt[1] ? m1_req_wmask : m0_req_wmask;
  assign sel_addr  = gnt[1] ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = gnt[1] ? m1_req_wdata : m0_req_wdata;

  // Hold off a port-1 read that would hit the word port 0 is writing this cycle.
  assign collision   = p0_accept && sel_we && (sel_addr == r_req_addr);
  assign r_req_ready = init_done_q && !collision;
  assign r_accept    = r_req_valid && r_req_ready;

  // FSM state and zero-fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StateAfterReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every address once, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = RUN;
      end
    end
  end

  // Port-0 command: zero-fill writes in INIT, otherwise the granted request or idle.
  always_comb begin
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = '0;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (state_q == INIT) begin
      csb0_d   = 1'b0;
      web0_d   = 1'b0;
      wmask0_d = '1;
      addr0_d  = cnt_q;
      din0_d   = '0;
    end else if (p0_accept) begin
      csb0_d   = 1'b0;
      web0_d   = !sel_we;
      wmask0_d = sel_we ? sel_wmask : '0;
      addr0_d  = sel_addr;
      din0_d   = sel_wdata;
    end
  end

  // Macro command registers; the macro acts on them at the following falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      csb1_q   <= 1'b1;
      addr1_q  <= '0;
    end else begin
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      csb1_q   <= !r_accept;
      if (r_accept) begin
        addr1_q <= r_req_addr;
      end
    end
  end

  // Ready flag, in-flight tracking and response capture one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q    <= 1'b0;
      pend_q         <= 2'b00;
      pend_we_q      <= 1'b0;
      r_pend_q       <= 1'b0;
      m0_rsp_valid_q <= 1'b0;
      m1_rsp_valid_q <= 1'b0;
      r_rsp_valid_q  <= 1'b0;
      m0_rsp_rdata_q <= '0;
      m1_rsp_rdata_q <= '0;
      r_rsp_rdata_q  <= '0;
    end else begin
      init_done_q    <= (state_q == RUN);
      pend_q         <= gnt;
      pend_we_q      <= sel_we;
      r_pend_q       <= r_accept;
      m0_rsp_valid_q <= pend_q[0];
      m1_rsp_valid_q <= pend_q[1];
      r_rsp_valid_q  <= r_pend_q;
      if (pend_q[0]) begin
        m0_rsp_rdata_q <= pend_we_q ? '0 : sram_dout0;
      end
      if (pend_q[1]) begin
        m1_rsp_rdata_q <= pend_we_q ? '0 : sram_dout0;
      end
      if (r_pend_q) begin
        r_rsp_rdata_q <= sram_dout1;
      end
    end
  end

  assign init_done    = init_done_q;
  assign m0_rsp_valid = m0_rsp_valid_q;
  assign m0_rsp_rdata = m0_rsp_rdata_q;
  assign m1_rsp_valid = m1_rsp_valid_q;
  assign m1_rsp_rdata = m1_rsp_rdata_q;
  assign r_rsp_valid  = r_rsp_valid_q;
  assign r_rsp_rdata  = r_rsp_rdata_q;
  assign sram_csb0    = csb0_q;
  assign sram_web0    = web0_q;
  assign sram_wmask0  = wmask0_q;
  assign sram_addr0   = addr0_q;
  assign sram_din0    = din0_q;
  assign sram_csb1    = csb1_q;
  assign sram_addr1   = addr1_q;

endmodule

// File: tb/tb_hdp_sram_port_ctrl.sv
// Bench for hdp_sram_port_ctrl: behavioural macro model, reference memory and
// per-port response scoreboard, plus a second instance with zero-fill disabled.
module tb_hdp_sram_port_ctrl;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_nz;

  logic          init_done;
  logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [NW-1:0] m0_req_wmask;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
  logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [NW-1:0] m1_req_wmask;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
  logic          r_req_valid, r_req_ready, r_rsp_valid;
  logic [AW-1:0] r_req_addr;
  logic [DW-1:0] r_rsp_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

  // Second instance, INIT_ZERO=0; only its m0 port is exercised.
  logic          nz_init_done, nz_m0_req_valid, nz_m0_req_ready, nz_m0_rsp_valid;
  logic [AW-1:0] nz_m0_req_addr;
  logic [DW-1:0] nz_m0_rsp_rdata;
  logic          nz_m1_req_ready, nz_m1_rsp_valid, nz_r_req_ready, nz_r_rsp_valid;
  logic [DW-1:0] nz_m1_rsp_rdata, nz_r_rsp_rdata, nz_din0, nz_dout0;
  logic          nz_csb0, nz_web0, nz_csb1;
  logic [NW-1:0] nz_wmask0;
  logic [AW-1:0] nz_addr0, nz_addr1;

  hdp_sram_port_ctrl #(.INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_wmask(m0_req_wmask), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_wmask(m1_req_wmask), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_rsp_valid(r_rsp_valid), .r_rsp_rdata(r_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  hdp_sram_port_ctrl #(.INIT_ZERO(0)) dut_nz (
    .clk(clk), .rst_n(rst_nz), .init_done(nz_init_done),
    .m0_req_valid(nz_m0_req_valid), .m0_req_ready(nz_m0_req_ready), .m0_req_we(1'b0),
    .m0_req_wmask(4'h0), .m0_req_addr(nz_m0_req_addr), .m0_req_wdata(32'h0),
    .m0_rsp_valid(nz_m0_rsp_valid), .m0_rsp_rdata(nz_m0_rsp_rdata),
    .m1_req_valid(1'b0), .m1_req_ready(nz_m1_req_ready), .m1_req_we(1'b0),
    .m1_req_wmask(4'h0), .m1_req_addr(11'h0), .m1_req_wdata(32'h0),
    .m1_rsp_valid(nz_m1_rsp_valid), .m1_rsp_rdata(nz_m1_rsp_rdata),
    .r_req_valid(1'b0), .r_req_ready(nz_r_req_ready), .r_req_addr(11'h0),
    .r_rsp_valid(nz_r_rsp_valid), .r_rsp_rdata(nz_r_rsp_rdata),
    .sram_csb0(nz_csb0), .sram_web0(nz_web0), .sram_wmask0(nz_wmask0),
    .sram_addr0(nz_addr0), .sram_din0(nz_din0), .sram_dout0(nz_dout0),
    .sram_csb1(nz_csb1), .sram_addr1(nz_addr1), .sram_dout1(32'h0)
  );

  // Macro model: acts on the falling edge; never-written words read back as garbage.
  logic [DW-1:0] mem [2048];
  bit            written [2048];
  always @(negedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < NW; b++) begin
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        end
        written[sram_addr0] <= 1'b1;
      end else begin
        sram_dout0 <= written[sram_addr0] ? mem[sram_addr0] : {21'h1BAD5, sram_addr0};
      end
    end
    if (!sram_csb1) begin
      sram_dout1 <= written[sram_addr1] ? mem[sram_addr1] : {21'h1BAD5, sram_addr1};
    end
  end

  // Read-only model for the second instance: contents are a function of the address.
  always @(negedge clk) begin
    if (!nz_csb0 && nz_web0) nz_dout0 <= 32'h5A5A0000 | {21'h0, nz_addr0};
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          expq [3][$];
  logic [DW-1:0] ref_mem [int];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic rsp_check(input int p, input logic v, input logic [DW-1:0] d);
    logic exp_v;
    exp_t e;
    exp_v = (expq[p].size() > 0) && (expq[p][0].due == cyc);
    if (v || exp_v) begin
      check($sformatf("port%0d_rsp_valid_at_%0d", p, cyc), v, exp_v);
      if (exp_v) begin
        e = expq[p].pop_front();
        if (v) check($sformatf("port%0d_rsp_rdata_at_%0d", p, cyc), d, e.data);
      end
    end
  endtask

  task automatic accept_p0(input int p, input logic we, input logic [NW-1:0] wm,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] w;
    exp_t e;
    if (we) begin
      w = ref_rd(a);
      for (int b = 0; b < NW; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[int'(a)] = w;
      e.data = '0;
    end else begin
      e.data = ref_rd(a);
    end
    e.due = cyc + 2;
    expq[p].push_back(e);
  endtask

  // Scoreboard: accepts seen before an edge produce a response two sample points later.
  always @(negedge clk) begin
    if (rst_n) begin
      rsp_check(0, m0_rsp_valid, m0_rsp_rdata);
      rsp_check(1, m1_rsp_valid, m1_rsp_rdata);
      rsp_check(2, r_rsp_valid, r_rsp_rdata);
      if (m0_req_valid && m0_req_ready)
        accept_p0(0, m0_req_we, m0_req_wmask, m0_req_addr, m0_req_wdata);
      if (m1_req_valid && m1_req_ready)
        accept_p0(1, m1_req_we, m1_req_wmask, m1_req_addr, m1_req_wdata);
      if (r_req_valid && r_req_ready) begin
        exp_t e;
        e.data = ref_rd(r_req_addr);
        e.due  = cyc + 2;
        expq[2].push_back(e);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {init_done, m0_req_ready, m1_req_ready, r_req_ready, m0_rsp_valid,
                          m1_rsp_valid, r_rsp_valid, sram_csb0, sram_web0, sram_csb1},
          64'b0000000111);
    check({tag, "_rdata"}, {m0_rsp_rdata, m1_rsp_rdata}, 64'h0);
    check({tag, "_sram"}, {r_rsp_rdata, sram_wmask0, sram_addr0, sram_addr1}, 64'h0);
    check({tag, "_din0"}, sram_din0, 64'h0);
  endtask

  task automatic issue(input int m, input logic we, input logic [NW-1:0] wm,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit got = 0;
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_req_valid = 1; m0_req_we = we; m0_req_wmask = wm; m0_req_addr = a; m0_req_wdata = wd;
    end else begin
      m1_req_valid = 1; m1_req_we = we; m1_req_wmask = wm; m1_req_addr = a; m1_req_wdata = wd;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (m == 0) ? m0_req_ready : m1_req_ready;
    end
    check($sformatf("m%0d_accept", m), got, 1);
    @(posedge clk);
    #1;
    m0_req_valid = 0;
    m1_req_valid = 0;
  endtask

  task automatic wait_rsp(input int p, input string tag, input logic [DW-1:0] exp);
    bit            found = 0;
    logic [DW-1:0] d = '0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      case (p)
        0:       if (m0_rsp_valid) begin found = 1; d = m0_rsp_rdata; end
        1:       if (m1_rsp_valid) begin found = 1; d = m1_rsp_rdata; end
        default: if (r_rsp_valid)  begin found = 1; d = r_rsp_rdata;  end
      endcase
    end
    check({tag, "_seen"}, found, 1);
    if (found) check(tag, d, exp);
  endtask

  int         bad;
  logic [1:0] g;

  initial begin
    rst_n = 0; rst_nz = 0;
    m0_req_valid = 0; m0_req_we = 0; m0_req_wmask = 0; m0_req_addr = 0; m0_req_wdata = 0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_wmask = 0; m1_req_addr = 0; m1_req_wdata = 0;
    r_req_valid = 0; r_req_addr = 0;
    nz_m0_req_valid = 1; nz_m0_req_addr = 11'h000;
    repeat (3) @(negedge clk);
    check_reset("reset");
    check("nz_reset_init_done", nz_init_done, 0);
    rst_n = 1; rst_nz = 1;

    // Zero-fill interrupted by reset after 1000 writes; dut_nz serves a read meanwhile.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(i) ||
          sram_wmask0 !== 4'hF || sram_din0 !== 32'h0 || init_done !== 1'b0 ||
          r_req_ready !== 1'b0) bad++;
      if (i == 0) begin
        check("nz_init_done_cycle1", nz_init_done, 1);
        check("nz_m0_ready_cycle1", nz_m0_req_ready, 1);
      end
      if (i == 1) begin
        check("nz_rsp_not_yet", nz_m0_rsp_valid, 0);
        nz_m0_req_valid = 0;
      end
      if (i == 2) begin
        check("nz_rsp_valid", nz_m0_rsp_valid, 1);
        check("nz_rsp_rdata", nz_m0_rsp_rdata, 32'h5A5A0000);
      end
      if (i == 3) check("nz_rsp_one_pulse", nz_m0_rsp_valid, 0);
    end
    check("init_seq_partial_bad_cycles", bad, 0);
    #1 rst_n = 0;
    #1 check_reset("mid_init_reset");
    repeat (3) @(negedge clk);

    // Full zero-fill with an m0 read of 0x7FF pending from the start.
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 11'h7FF;
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(i) ||
          sram_wmask0 !== 4'hF || sram_din0 !== 32'h0 || init_done !== 1'b0 ||
          m0_req_ready !== 1'b0 || r_req_ready !== 1'b0) bad++;
    end
    check("init_seq_full_bad_cycles", bad, 0);
    @(negedge clk);
    check("init_done_cycle_2049", init_done, 1);
    check("m0_ready_after_init", m0_req_ready, 1);
    @(posedge clk);
    #1 m0_req_valid = 0;
    wait_rsp(0, "m0_read_7ff_zero", 32'h0);

    // Byte-masked write from m1 over a full-word preload.
    issue(0, 1, 4'hF, 11'h010, 32'h11223344);
    wait_rsp(0, "m0_preload_ack", 32'h0);
    issue(1, 1, 4'b0101, 11'h010, 32'hDEADBEEF);
    check("m1_write_cmd", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {1'b0, 1'b0, 4'b0101, 11'h010, 32'hDEADBEEF});
    wait_rsp(1, "m1_write_ack", 32'h0);
    issue(1, 0, 4'h0, 11'h010, 32'h0);
    wait_rsp(1, "m1_masked_read", 32'h11AD33EF);
    check("idle_port0", {sram_csb0, sram_web0, sram_wmask0, sram_addr0},
          {1'b1, 1'b1, 4'h0, 11'h010});

    // Both masters requesting continuously for six cycles.
    @(posedge clk);
    #1;
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 11'h020;
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 11'h010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = {m1_req_ready, m0_req_ready};
      check($sformatf("rr_grant_%0d", i), g, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk);
    #1 m0_req_valid = 0; m1_req_valid = 0;
    repeat (4) @(negedge clk);

    // Port-1 read colliding with an m1 write to the same word.
    @(posedge clk);
    #1;
    m1_req_valid = 1; m1_req_we = 1; m1_req_wmask = 4'hF;
    m1_req_addr = 11'h0AA; m1_req_wdata = 32'hCAFEF00D;
    r_req_valid = 1; r_req_addr = 11'h0AA;
    @(negedge clk);
    check("collision_m1_ready", m1_req_ready, 1);
    check("collision_r_stalled", r_req_ready, 0);
    @(posedge clk);
    #1 m1_req_valid = 0;
    @(negedge clk);
    check("collision_r_retry_ready", r_req_ready, 1);
    @(posedge clk);
    #1 r_req_valid = 0;
    wait_rsp(2, "r_read_after_collision", 32'hCAFEF00D);

    // A same-address read on port 0 does not stall port 1.
    @(posedge clk);
    #1;
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 11'h0AA;
    r_req_valid = 1; r_req_addr = 11'h0AA;
    @(negedge clk);
    check("rd_rd_same_addr_r_ready", {m0_req_ready, r_req_ready}, 2'b11);
    @(posedge clk);
    #1 m0_req_valid = 0; r_req_valid = 0;
    repeat (3) @(negedge clk);

    // Back-to-back write then read of the same word by m0.
    @(posedge clk);
    #1;
    m0_req_valid = 1; m0_req_we = 1; m0_req_wmask = 4'hF;
    m0_req_addr = 11'h055; m0_req_wdata = 32'h12345678;
    @(negedge clk);
    check("b2b_write_ready", m0_req_ready, 1);
    @(posedge clk);
    #1 m0_req_we = 0;
    @(negedge clk);
    check("b2b_read_ready", m0_req_ready, 1);
    @(posedge clk);
    #1 m0_req_valid = 0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", expq[0].size() + expq[1].size() + expq[2].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
